pkt_demux_conf: RTL and testbench

- Ingress classifier directly upstream of the configuration/print engine.
- Takes the 134-bit packet stream from the network side and steers each packet to one of two ports:
  - configuration packets (head-beat byte data_in[31:24] == CONF_ETYPE_HI) go to the conf port, which feeds the conf engine;
  - all other packets go to the CPU/LwIP port.
- Registered single-cycle pipeline with packet-framing checks. Malformed framing is dropped or cleanly terminated so that no downstream packet is left unclosed.

---
 rtl/pkt_demux_conf.sv | 170 +++++++++++++++++
 tb/tb_pkt_demux_conf.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_demux_conf.sv
// pkt_demux_conf: ingress classifier in front of the configuration engine.
// Steers each 134-bit packet to the conf port (head byte [31:24] matches
// CONF_ETYPE_HI) or to the CPU port, one registered cycle later, and closes
// or drops malformed framing so no downstream packet is left open.
//
// Ports:
//   clk, resetn                 clock, async active-low reset
//   data_in_valid, data_in      ingress beat {tag[1:0], bv[3:0], payload[127:0]}
//   conf_data_valid, conf_data  conf engine port
//   cpu_data_valid, cpu_data    CPU/LwIP port
//   frame_err                   one-cycle pulse per framing error
//   conf_pkt_cnt, cpu_pkt_cnt,  saturating statistics counters
//   err_cnt                     (only when PKT_CNT_EN is defined)
//
// Optional feature macro: PKT_CNT_EN
module pkt_demux_conf #(
  parameter logic [7:0]  CONF_ETYPE_HI = 8'h90,
  parameter int unsigned CNT_W         = 16
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           data_in_valid,
  input  logic [133:0]   data_in,
  output logic           conf_data_valid,
  output logic [133:0]   conf_data,
  output logic           cpu_data_valid,
  output logic [133:0]   cpu_data,
`ifdef PKT_CNT_EN
  output logic [CNT_W-1:0] conf_pkt_cnt,
  output logic [CNT_W-1:0] cpu_pkt_cnt,
  output logic [CNT_W-1:0] err_cnt,
`endif
  output logic           frame_err
);

  localparam logic [1:0] TAG_MID  = 2'b00;
  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  typedef enum logic [1:0] {IDLE, FWD_CONF, FWD_CPU, DROP} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_conf_v, r_cpu_v, r_frame_err;
  logic [133:0]   r_conf_data, r_cpu_data;
  logic           w_conf_v, w_cpu_v, w_err;
  logic [133:0]   w_conf_d, w_cpu_d;
  logic [1:0]     w_tag;
  logic           w_is_conf;

  // A zero-width counter is meaningless even when counters are compiled out.
  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("CNT_W must be nonzero");
  end

  assign w_tag     = data_in[133:132];
  assign w_is_conf = (data_in[31:24] == CONF_ETYPE_HI);

  // State register and output pipeline registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_conf_v    <= 1'b0;
      r_cpu_v     <= 1'b0;
      r_conf_data <= '0;
      r_cpu_data  <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_conf_v    <= w_conf_v;
      r_cpu_v     <= w_cpu_v;
      r_conf_data <= w_conf_d;
      r_cpu_data  <= w_cpu_d;
      r_frame_err <= w_err;
    end
  end

  // Next state and next output values. Data registers hold by default;
  // a forced tail replays the held register with its tag rewritten.
  always_comb begin
    w_state_nxt = r_state;
    w_conf_v    = 1'b0;
    w_cpu_v     = 1'b0;
    w_conf_d    = r_conf_data;
    w_cpu_d     = r_cpu_data;
    w_err       = 1'b0;
    if (data_in_valid) begin
      unique case (r_state)
        IDLE: begin
          if (w_tag == TAG_HEAD) begin
            if (w_is_conf) begin
              w_conf_v    = 1'b1;
              w_conf_d    = data_in;
              w_state_nxt = FWD_CONF;
            end else begin
              w_cpu_v     = 1'b1;
              w_cpu_d     = data_in;
              w_state_nxt = FWD_CPU;
            end
          end else begin
            w_err = 1'b1;
          end
        end
        FWD_CONF: begin
          w_conf_v = 1'b1;
          if (w_tag == TAG_MID || w_tag == TAG_TAIL) begin
            w_conf_d = data_in;
            if (w_tag == TAG_TAIL) w_state_nxt = IDLE;
          end else begin
            w_conf_d    = {TAG_TAIL, r_conf_data[131:0]};
            w_err       = 1'b1;
            w_state_nxt = (w_tag == TAG_HEAD) ? DROP : IDLE;
          end
        end
        FWD_CPU: begin
          w_cpu_v = 1'b1;
          if (w_tag == TAG_MID || w_tag == TAG_TAIL) begin
            w_cpu_d = data_in;
            if (w_tag == TAG_TAIL) w_state_nxt = IDLE;
          end else begin
            w_cpu_d     = {TAG_TAIL, r_cpu_data[131:0]};
            w_err       = 1'b1;
            w_state_nxt = (w_tag == TAG_HEAD) ? DROP : IDLE;
          end
        end
        DROP: begin
          if (w_tag == TAG_TAIL) begin
            w_state_nxt = IDLE;
          end else if (w_tag != TAG_MID) begin
            w_err = 1'b1;
            if (w_tag != TAG_HEAD) w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign conf_data_valid = r_conf_v;
  assign conf_data       = r_conf_data;
  assign cpu_data_valid  = r_cpu_v;
  assign cpu_data        = r_cpu_data;
  assign frame_err       = r_frame_err;

`ifdef PKT_CNT_EN
  logic [CNT_W-1:0] r_conf_cnt, r_cpu_cnt, r_err_cnt;
  logic             w_conf_head, w_cpu_head;

  assign w_conf_head = data_in_valid && (r_state == IDLE) && (w_tag == TAG_HEAD) && w_is_conf;
  assign w_cpu_head  = data_in_valid && (r_state == IDLE) && (w_tag == TAG_HEAD) && !w_is_conf;

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_conf_cnt <= '0;
      r_cpu_cnt  <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (w_conf_head && r_conf_cnt != '1) r_conf_cnt <= r_conf_cnt + CNT_W'(1);
      if (w_cpu_head  && r_cpu_cnt  != '1) r_cpu_cnt  <= r_cpu_cnt  + CNT_W'(1);
      if (w_err       && r_err_cnt  != '1) r_err_cnt  <= r_err_cnt  + CNT_W'(1);
    end
  end

  assign conf_pkt_cnt = r_conf_cnt;
  assign cpu_pkt_cnt  = r_cpu_cnt;
  assign err_cnt      = r_err_cnt;
`endif

endmodule

// File: tb/tb_pkt_demux_conf.sv
// Scoreboard bench for pkt_demux_conf: expected port beats and frame_err
// pulses are queued at stimulus time and popped by an independent monitor.
module tb_pkt_demux_conf;

  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          data_in_valid = 1'b0;
  logic [133:0]  data_in = '0;
  logic          conf_data_valid, cpu_data_valid, frame_err;
  logic [133:0]  conf_data, cpu_data;
`ifdef PKT_CNT_EN
  logic [CW-1:0] conf_pkt_cnt, cpu_pkt_cnt, err_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [133:0] exp_conf[$];
  logic [133:0] exp_cpu[$];
  int           exp_err[$];

  pkt_demux_conf #(.CONF_ETYPE_HI(8'h90), .CNT_W(CW)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_in_valid   (data_in_valid),
    .data_in         (data_in),
    .conf_data_valid (conf_data_valid),
    .conf_data       (conf_data),
    .cpu_data_valid  (cpu_data_valid),
    .cpu_data        (cpu_data),
`ifdef PKT_CNT_EN
    .conf_pkt_cnt    (conf_pkt_cnt),
    .cpu_pkt_cnt     (cpu_pkt_cnt),
    .err_cnt         (err_cnt),
`endif
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [133:0] mk(input logic [1:0] tag, input logic [7:0] et,
                                      input logic [31:0] f);
    logic [127:0] p;
    p = {f, ~f, f ^ 32'h5a5a5a5a, f};
    p[31:24] = et;
    p[17:16] = 2'd3;
    return {tag, 4'hf, p};
  endfunction

  function automatic logic [133:0] as_tail(input logic [133:0] b);
    return {2'b10, b[131:0]};
  endfunction

  task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [133:0] d);
    @(posedge clk); #1;
    data_in_valid = 1'b1;
    data_in       = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      data_in_valid = 1'b0;
    end
  endtask

  // Forward a beat and queue it for the given port (1 = conf, 0 = cpu).
  task automatic fwd(input logic [133:0] d, input bit to_conf);
    if (to_conf) exp_conf.push_back(d); else exp_cpu.push_back(d);
    drive(d);
  endtask

  // Monitor: every presented output must match the head of its queue.
  always @(negedge clk) begin
    if (resetn) begin
      if (conf_data_valid && cpu_data_valid) begin
        n_cmp++; n_bad++;
        $display("FAIL both_valid: got conf=1 cpu=1 expected at most one");
      end
      if (conf_data_valid) begin
        if (exp_conf.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL conf_unexpected: got beat %h expected none", conf_data);
        end else check("conf_beat", conf_data, exp_conf.pop_front());
      end
      if (cpu_data_valid) begin
        if (exp_cpu.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL cpu_unexpected: got beat %h expected none", cpu_data);
        end else check("cpu_beat", cpu_data, exp_cpu.pop_front());
      end
      if (frame_err) begin
        if (exp_err.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL err_unexpected: got frame_err=1 expected 0");
        end else begin
          n_cmp++;
          void'(exp_err.pop_front());
        end
      end
    end
  end

  task automatic drain_check(input string tname);
    idle(3);
    check({tname, "_conf_left"}, 134'(exp_conf.size()), 134'(0));
    check({tname, "_cpu_left"},  134'(exp_cpu.size()),  134'(0));
    check({tname, "_err_left"},  134'(exp_err.size()),  134'(0));
    exp_conf.delete(); exp_cpu.delete(); exp_err.delete();
  endtask

  initial begin
    logic [133:0] h, m1, h2;

    // Reset state
    #3;
    check("rst_conf_valid", 134'(conf_data_valid), 134'(0));
    check("rst_cpu_valid",  134'(cpu_data_valid),  134'(0));
    check("rst_conf_data",  conf_data, '0);
    check("rst_cpu_data",   cpu_data,  '0);
    check("rst_frame_err",  134'(frame_err), 134'(0));
    @(posedge clk); #1 resetn = 1'b1;

    // Conf packet, 5 continuous beats
    fwd(mk(2'b01, 8'h90, 32'h1111_0001), 1);
    for (int i = 0; i < 3; i++) fwd(mk(2'b00, 8'h00, 32'h2222_0000 + 32'(i)), 1);
    fwd(mk(2'b10, 8'h00, 32'h3333_0003), 1);
    drain_check("conf_pkt");

    // CPU packet then back-to-back conf packet
    fwd(mk(2'b01, 8'h08, 32'h4444_0001), 0);
    fwd(mk(2'b10, 8'h90, 32'h4444_0002), 0);
    fwd(mk(2'b01, 8'h90, 32'h5555_0001), 1);
    fwd(mk(2'b10, 8'h00, 32'h5555_0002), 1);
    drain_check("b2b");

    // Gapped conf packet; data register holds through gaps
    fwd(mk(2'b01, 8'h90, 32'h6666_0001), 1);
    idle(4);
    check("gap_hold", conf_data, mk(2'b01, 8'h90, 32'h6666_0001));
    fwd(mk(2'b00, 8'h00, 32'h6666_0002), 1);
    idle(2);
    fwd(mk(2'b10, 8'h00, 32'h6666_0003), 1);
    drain_check("gapped");

    // Unexpected head: M1 replayed as tail, H2 packet dropped
    h  = mk(2'b01, 8'h90, 32'h7777_0001);
    m1 = mk(2'b00, 8'h00, 32'h7777_0002);
    fwd(h, 1);
    fwd(m1, 1);
    exp_conf.push_back(as_tail(m1)); exp_err.push_back(1);
    drive(mk(2'b01, 8'h08, 32'h8888_0001));
    drive(mk(2'b00, 8'h00, 32'h8888_0002));
    drive(mk(2'b10, 8'h00, 32'h8888_0003));
    fwd(mk(2'b01, 8'h08, 32'h9999_0001), 0);
    fwd(mk(2'b10, 8'h00, 32'h9999_0002), 0);
    drain_check("unexp_head");

    // Head replayed as tail; heads in DROP err; illegal tag in FWD_CPU
    h2 = mk(2'b01, 8'h90, 32'haaaa_0001);
    fwd(h2, 1);
    exp_conf.push_back(as_tail(h2)); exp_err.push_back(1);
    drive(mk(2'b01, 8'h90, 32'haaaa_0002));
    exp_err.push_back(1);
    drive(mk(2'b01, 8'h90, 32'haaaa_0003));
    drive(mk(2'b10, 8'h00, 32'haaaa_0004));
    h2 = mk(2'b01, 8'h08, 32'hbbbb_0001);
    fwd(h2, 0);
    exp_cpu.push_back(as_tail(h2)); exp_err.push_back(1);
    drive(mk(2'b11, 8'h00, 32'hbbbb_0002));
    fwd(mk(2'b01, 8'h08, 32'hbbbb_0003), 0);
    fwd(mk(2'b10, 8'h00, 32'hbbbb_0004), 0);
    drain_check("forced_tail");

    // Async reset mid-packet
    fwd(mk(2'b01, 8'h90, 32'hcccc_0001), 1);
    drive(mk(2'b00, 8'h00, 32'hcccc_0002));
    @(posedge clk); #2;
    resetn = 1'b0;
    data_in_valid = 1'b0;
    #1;
    check("arst_conf_valid", 134'(conf_data_valid), 134'(0));
    check("arst_conf_data",  conf_data, '0);
    check("arst_cpu_data",   cpu_data,  '0);
    check("arst_frame_err",  134'(frame_err), 134'(0));
    @(posedge clk); #1 resetn = 1'b1;
    fwd(mk(2'b01, 8'h90, 32'hdddd_0001), 1);
    fwd(mk(2'b10, 8'h00, 32'hdddd_0002), 1);
    drain_check("post_rst");

    // Orphan middle and illegal beat in IDLE
    exp_err.push_back(1);
    drive(mk(2'b00, 8'h00, 32'heeee_0001));
    exp_err.push_back(1);
    drive(mk(2'b11, 8'h90, 32'heeee_0002));
    drain_check("orphan");
`ifdef PKT_CNT_EN
    check("err_cnt",      134'(err_cnt),      134'(2));
    check("conf_cnt_one", 134'(conf_pkt_cnt), 134'(1));
    check("cpu_cnt_zero", 134'(cpu_pkt_cnt),  134'(0));
    for (int i = 0; i < 4; i++) begin
      fwd(mk(2'b01, 8'h90, 32'hf000_0000 + 32'(i)), 1);
      fwd(mk(2'b10, 8'h00, 32'hf100_0000 + 32'(i)), 1);
    end
    drain_check("sat");
    check("conf_cnt_sat", 134'(conf_pkt_cnt), 134'(3));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
